pio_edge_capture_in: RTL

PIO_EDGE_CAPTURE_IN -- requirements
Module: pio_edge_capture_in

---
 rtl/pio_edge_capture_in_pkg.sv | 19 +
 rtl/pio_sync_chain.sv | 32 +++
 rtl/pio_edge_capture_in.sv | 114 +++++++++++
 3 files changed

// File: rtl/pio_edge_capture_in_pkg.sv
// PIO edge-capture input port: shared constants.
// Register map and edge-mode encodings.
package pio_edge_capture_in_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Cycles after reset release before edges count:
  // lets the chain and prev_q fill with real input.
  function automatic logic [2:0] arm_len(input int stages);
    return 3'(stages + 1);
  endfunction

endpackage

// File: rtl/pio_sync_chain.sv
// Per-bit multi-flop synchronizer for async inputs.
// dout is the last stage of the chain.
module pio_sync_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  // Shift the input one stage deeper every cycle
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], din};
  end

  // Chain registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/pio_edge_capture_in.sv
// PIO input port with per-bit edge capture,
// irq masking and an Avalon-MM slave.
module pio_edge_capture_in
  import pio_edge_capture_in_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] ARM_LEN = arm_len(SYNC_STAGES);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      rdata_q, rdata_d;
  logic [2:0]       arm_q, arm_d;
  logic             armed;
  logic             rd_en;
  logic             wr_en;
  logic             unused_wdata;

  pio_sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (in_port),
    .dout    (sync_q)
  );

  assign rd_en = chipselect & ~read_n;
  assign wr_en = chipselect & ~write_n;
  assign armed = (arm_q == ARM_LEN);

  // Upper write bits have no home in a narrow port
  assign unused_wdata = ^writedata;

  // Edge detect in the configured mode, gated until armed
  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      EDGE_FALLING: edge_raw = ~sync_q & prev_q;
      EDGE_ANY:     edge_raw = sync_q ^ prev_q;
      default:      edge_raw = sync_q & ~prev_q;
    endcase
    edge_det = armed ? edge_raw : '0;
  end

  // Next-state for mask, capture (set beats clear), arm counter
  always_comb begin
    prev_d   = sync_q;
    mask_d   = mask_q;
    clr_bits = '0;
    if (wr_en && address == ADDR_IRQMASK) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == ADDR_EDGECAP) begin
      clr_bits = writedata[WIDTH-1:0];
    end
    cap_d = (cap_q & ~clr_bits) | edge_det;
    arm_d = armed ? arm_q : arm_q + 3'd1;
  end

  // Read mux; readdata holds when no read is active
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (address)
        ADDR_DATA:    rdata_d = 32'(sync_q);
        ADDR_IRQMASK: rdata_d = 32'(mask_q);
        ADDR_EDGECAP: rdata_d = 32'(cap_q);
        default:      rdata_d = '0;
      endcase
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      arm_q   <= '0;
    end else begin
      prev_q  <= prev_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      arm_q   <= arm_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule
